// File: rtl/key_press_ctrl.sv
// Raw-input conditioner: synchronizer chain, 4-state debounce FSM, press/release pulses, held level.
// Optional auto-repeat of the press pulse when KEY_PRESS_CTRL_AUTO_REPEAT_EN is defined.
module key_press_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic press,
  output logic released,   // release pulse; "release" is a reserved word
  output logic held,
  output logic sync_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Each stage lives in its own generate scope so every flop has a single driver.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      logic stage_reg;
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (!reset) stage_reg <= 1'b0;
          else        stage_reg <= in;
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (!reset) stage_reg <= 1'b0;
          else        stage_reg <= g_sync[gi-1].stage_reg;
        end
      end
    end

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
    begin : g_invalid_params
    end
  endgenerate

  logic s;
  assign s        = g_sync[SYNC_STAGES-1].stage_reg;
  assign sync_out = s;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          press_reg, press_next;
  logic          release_reg, release_next;
  logic          held_reg, held_next;

`ifdef KEY_PRESS_CTRL_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] REP_DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rep_cnt_reg, rep_cnt_next;
  logic          rep_first_reg, rep_first_next;
  logic [RW-1:0] rep_target;
  assign rep_target = rep_first_reg ? REP_DELAY_LAST : REP_PERIOD_LAST;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      held_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      press_reg   <= press_next;
      release_reg <= release_next;
      held_reg    <= held_next;
    end
  end

`ifdef KEY_PRESS_CTRL_AUTO_REPEAT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      rep_cnt_reg   <= '0;
      rep_first_reg <= 1'b1;
    end else begin
      rep_cnt_reg   <= rep_cnt_next;
      rep_first_reg <= rep_first_next;
    end
  end
`endif

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    held_next    = held_reg;
`ifdef KEY_PRESS_CTRL_AUTO_REPEAT_EN
    rep_cnt_next   = rep_cnt_reg;
    rep_first_next = rep_first_reg;
`endif
    case (state_reg)
      IDLE: begin
        held_next = 1'b0;
        if (s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_next = HELD;
            cnt_next   = '0;
            press_next = 1'b1;
            held_next  = 1'b1;
`ifdef KEY_PRESS_CTRL_AUTO_REPEAT_EN
            rep_cnt_next   = '0;
            rep_first_next = 1'b1;
`endif
          end else begin
            state_next = PRESS_WAIT;
            cnt_next   = CNT_ONE;
          end
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = HELD;
          cnt_next   = '0;
          press_next = 1'b1;
          held_next  = 1'b1;
`ifdef KEY_PRESS_CTRL_AUTO_REPEAT_EN
          rep_cnt_next   = '0;
          rep_first_next = 1'b1;
`endif
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      HELD: begin
        held_next = 1'b1;
        if (!s) begin
`ifdef KEY_PRESS_CTRL_AUTO_REPEAT_EN
          rep_cnt_next = '0;
`endif
          if (DEBOUNCE_CYCLES == 1) begin
            state_next   = IDLE;
            cnt_next     = '0;
            release_next = 1'b1;
            held_next    = 1'b0;
          end else begin
            state_next = RELEASE_WAIT;
            cnt_next   = CNT_ONE;
          end
        end else begin
`ifdef KEY_PRESS_CTRL_AUTO_REPEAT_EN
          // First repeat waits the long delay, later ones the short period.
          if (rep_cnt_reg == rep_target) begin
            press_next     = 1'b1;
            rep_cnt_next   = '0;
            rep_first_next = 1'b0;
          end else begin
            rep_cnt_next = rep_cnt_reg + RW'(1);
          end
`endif
        end
      end
      RELEASE_WAIT: begin
        held_next = 1'b1;
        if (s) begin
          state_next = HELD;
          cnt_next   = '0;
`ifdef KEY_PRESS_CTRL_AUTO_REPEAT_EN
          rep_cnt_next   = '0;
          rep_first_next = 1'b1;
`endif
        end else if (cnt_reg == CNT_LAST) begin
          state_next   = IDLE;
          cnt_next     = '0;
          release_next = 1'b1;
          held_next    = 1'b0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        held_next  = 1'b0;
      end
    endcase
  end

  assign press    = press_reg;
  assign released = release_reg;
  assign held     = held_reg;

endmodule

// File: tb/tb_key_press_ctrl.sv
// Self-checking bench for key_press_ctrl (default parameters); honours KEY_PRESS_CTRL_AUTO_REPEAT_EN.
module tb_key_press_ctrl;

  typedef struct {
    logic rst;
    logic din;
    logic ep;
    logic er;
    logic eh;
    logic es;
    int   tag;
  } vec_t;

  logic clk;
  logic reset;
  logic in_r;
  logic press, released, held, sync_out;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[$];
  vec_t exp_q[$];
  logic s1_m = 1'b0;
  logic s2_m = 1'b0;

  key_press_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in_r),
    .press    (press),
    .released (released),
    .held     (held),
    .sync_out (sync_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Builds one vector; the two-flop synchronizer expectation is tracked alongside.
  function automatic vec_t mk(input logic r, input logic i, input logic p,
                              input logic rl, input logic h, input int tag);
    vec_t v;
    if (!r) begin
      s1_m = 1'b0;
      s2_m = 1'b0;
    end else begin
      s2_m = s1_m;
      s1_m = i;
    end
    v.rst = r; v.din = i; v.ep = p; v.er = rl; v.eh = h; v.es = s2_m; v.tag = tag;
    return v;
  endfunction

  task automatic chk(input string nm, input int tag, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL t%0d %s: got %0b want %0b at %0t", tag, nm, got, want, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    reset = v.rst;
    in_r  = v.din;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    $display("t%0d rst=%0b in=%0b -> press=%0b rel=%0b held=%0b sync=%0b",
             e.tag, e.rst, e.din, press, released, held, sync_out);
    chk("press", e.tag, press, e.ep);
    chk("release", e.tag, released, e.er);
    chk("held", e.tag, held, e.eh);
    chk("sync_out", e.tag, sync_out, e.es);
    chk("exclusive", e.tag, press & released, 1'b0);
  endtask

  initial begin
    vec_t v;
    int   d;
    logic ep;
    reset = 1'b0;
    in_r  = 1'b0;

    // 1: reset with input high, then a clean press (pulse after E6)
    for (int k = 0; k < 2; k++) vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1));
    for (int k = 1; k <= 7; k++) vecs.push_back(mk(1'b1, 1'b1, k == 6, 1'b0, k >= 6, 1));
    // 2: clean release
    for (int k = 1; k <= 7; k++) vecs.push_back(mk(1'b1, 1'b0, 1'b0, k == 6, k < 6, 2));
    // 3: short press bounce is filtered
    for (int k = 0; k < 2; k++) vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3));
    for (int k = 0; k < 8; k++) vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3));
    // press again to reach HELD
    for (int k = 1; k <= 7; k++) vecs.push_back(mk(1'b1, 1'b1, k == 6, 1'b0, k >= 6, 4));
    // 4: short release glitch is filtered, no second press
    for (int k = 0; k < 2; k++) vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4));
    for (int k = 0; k < 8; k++) vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4));
    // 5: reset while held drops held silently; the still-high input is a new press
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5));
    for (int k = 1; k <= 7; k++) vecs.push_back(mk(1'b1, 1'b1, k == 6, 1'b0, k >= 6, 5));

    for (int n = 0; n < vecs.size(); n++) apply(vecs[n]);

    // 6: long hold after the test-5 press (press edge was k=6)
    for (int k = 8; k <= 57; k++) begin
      d  = k - 6;
      ep = 1'b0;
`ifdef KEY_PRESS_CTRL_AUTO_REPEAT_EN
      ep = (d >= 16) && (((d - 16) % 8) == 0);
`endif
      v = mk(1'b1, 1'b1, ep, 1'b0, 1'b1, 6);
      apply(v);
    end

    // 7: release after the long hold is still clean
    for (int k = 1; k <= 7; k++) begin
      v = mk(1'b1, 1'b0, 1'b0, k == 6, k < 6, 7);
      apply(v);
    end

    chk("queue_drained", 8, exp_q.size() == 0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
